// File: rtl/seg7_pkg.sv
// Shared 7-segment constants: active-low glyph table (bit order g..a),
// dash/blank patterns and helpers used by the scan driver and converter.
package seg7_pkg;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Entry [d] is the glyph for hex digit d.
  localparam logic [15:0][6:0] GLYPH_TAB = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  function automatic logic [6:0] digit_glyph(input logic [3:0] d);
    return GLYPH_TAB[d];
  endfunction

  // ceil(w * 0.302) + 1 BCD digits, in integer arithmetic.
  function automatic int bcd_digits(input int w);
    return (w * 302 + 999) / 1000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per cycle.
// done pulses for one cycle once the last bit has been shifted in.
import seg7_pkg::*;

module bin2bcd_seq #(
  parameter int DATA_W = 16,
  parameter int BCD_D  = bcd_digits(DATA_W)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_W-1:0]    din,
  output logic                 busy,
  output logic                 done,
  output logic [BCD_D*4-1:0]   bcd
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  sh_q, sh_d;
  logic [BCD_D*4-1:0] bcd_q, bcd_d, adj;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d, done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_D; i++)
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    sh_d   = sh_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (start && !busy_q) begin
      sh_d   = din;
      bcd_d  = '0;
      cnt_d  = CNT_W'(DATA_W);
      busy_d = 1'b1;
    end else if (busy_q) begin
      bcd_d = {adj[BCD_D*4-2:0], sh_q[DATA_W-1]};
      sh_d  = sh_q << 1;
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment driver: latches a value, converts it to hex or BCD
// digits, and scans the digits out with live leading-zero blanking.
import seg7_pkg::*;

module seg7_scan_driver #(
  parameter int N_DIGITS = 4,
  parameter int DATA_W   = 16,
  parameter int SCAN_DIV = 50000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic [DATA_W-1:0]   value,
  input  logic                dec_mode,
  input  logic                lz_blank,
  output logic                busy,
  output logic                overflow,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] dig_en
);

  localparam int BCD_D = bcd_digits(DATA_W);
  localparam int EXT_D = (BCD_D > N_DIGITS) ? BCD_D : N_DIGITS;
  localparam int EXT_W = EXT_D * 4;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = $clog2(SCAN_DIV);

  logic                  busy_q, busy_d, mode_q, mode_d, ovf_q, ovf_d;
  logic [DATA_W-1:0]     val_q, val_d;
  logic [N_DIGITS*4-1:0] disp_q, disp_d, upper;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [N_DIGITS-1:0]   dig_en_q, dig_en_d;
  logic                  start, conv_done, conv_busy_unused;
  logic [BCD_D*4-1:0]    conv_bcd;
  logic [EXT_W-1:0]      cand;

  assign start = load && !busy_q;

  bin2bcd_seq #(.DATA_W(DATA_W), .BCD_D(BCD_D)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start && dec_mode),
    .din   (value),
    .busy  (conv_busy_unused),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Display register and overflow only change together, when busy drops.
  always_comb begin
    cand   = mode_q ? EXT_W'(conv_bcd) : EXT_W'(val_q);
    busy_d = busy_q;
    mode_d = mode_q;
    val_d  = val_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    if (start) begin
      busy_d = 1'b1;
      mode_d = dec_mode;
      val_d  = value;
    end else if (busy_q && (!mode_q || conv_done)) begin
      busy_d = 1'b0;
      disp_d = cand[N_DIGITS*4-1:0];
      ovf_d  = |(cand >> (N_DIGITS * 4));
    end
  end

  // Outputs are built from next-state index/display so seg and dig_en
  // switch on the same edge as the index itself.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    idx_d = idx_q;
    if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    end
    upper = disp_d >> (4 * idx_d);
    if (ovf_d)
      seg_d = SEG_DASH;
    else if (lz_blank && idx_d != '0 && upper == '0)
      seg_d = SEG_BLANK;
    else
      seg_d = digit_glyph(upper[3:0]);
    dig_en_d = ~(N_DIGITS'(1) << idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      mode_q   <= 1'b0;
      val_q    <= '0;
      disp_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      idx_q    <= '0;
      seg_q    <= SEG_BLANK;
      dig_en_q <= '1;
    end else begin
      busy_q   <= busy_d;
      mode_q   <= mode_d;
      val_q    <= val_d;
      disp_q   <= disp_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      seg_q    <= seg_d;
      dig_en_q <= dig_en_d;
    end
  end

  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign seg      = seg_q;
  assign dig_en   = dig_en_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (4 digits, 16-bit, SCAN_DIV=4).
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int DW = 16;
  localparam int SD = 4;

  logic          clk, rst_n, load, dec_mode, lz_blank;
  logic [DW-1:0] value;
  logic          busy, overflow;
  logic [6:0]    seg;
  logic [ND-1:0] dig_en;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int unsigned v;
    bit          dec;
    logic [6:0]  seg [ND];
    bit          ovf;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  logic [6:0] GL [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                          7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                          7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seg7_scan_driver #(.N_DIGITS(ND), .DATA_W(DW), .SCAN_DIV(SD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .value    (value),
    .dec_mode (dec_mode),
    .lz_blank (lz_blank),
    .busy     (busy),
    .overflow (overflow),
    .seg      (seg),
    .dig_en   (dig_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input int unsigned v, input bit dec, input bit lz);
    exp_t e;
    int unsigned base, pw, q;
    base = dec ? 10 : 16;
    pw = 1;
    for (int k = 0; k < ND; k++) pw = pw * base;
    e.v = v; e.dec = dec; e.ovf = (v >= pw);
    q = v;
    for (int k = 0; k < ND; k++) begin
      if (e.ovf)                 e.seg[k] = 7'b0111111;
      else if (lz && k > 0 && q == 0) e.seg[k] = 7'b1111111;
      else                       e.seg[k] = GL[q % base];
      q = q / base;
    end
    return e;
  endfunction

  function automatic int idx_of(input logic [ND-1:0] en);
    logic [ND-1:0] m;
    for (int k = 0; k < ND; k++) begin
      m = ~(ND'(1) << k);
      if (en === m) return k;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seg_now(input string tag, input exp_t e);
    int k;
    k = idx_of(dig_en);
    chk({tag, "_onehot"}, 32'(k >= 0), 32'd1);
    if (k >= 0) chk(tag, 32'(seg), 32'(e.seg[k]));
  endtask

  task automatic check_display(input string tag, input exp_t e);
    for (int c = 0; c < ND * SD; c++) begin
      chk_seg_now(tag, e);
      tick();
    end
    chk({tag, "_ovf"}, 32'(overflow), 32'(e.ovf));
  endtask

  // Drives one load, optionally re-strobes load at busy cycle inject_at,
  // and checks busy length, held display and final display.
  task automatic do_load(input string tag, input int unsigned v, input bit dec,
                         input int exp_busy, input int inject_at);
    int n;
    value = v[DW-1:0]; dec_mode = dec; load = 1'b1;
    sb.push_back(model(v, dec, lz_blank));
    tick();
    load = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      n++;
      chk_seg_now({tag, "_hold"}, model(cur.v, cur.dec, lz_blank));
      if (n == inject_at) begin
        value = 16'h0001; dec_mode = 1'b0; load = 1'b1;
      end
      tick();
      load = 1'b0;
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(exp_busy));
    cur = sb.pop_front();
    check_display(tag, cur);
  endtask

  initial begin
    rst_n = 1'b1; load = 1'b0; value = '0; dec_mode = 1'b0; lz_blank = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_seg",    32'(seg),      32'h7F);
    chk("rst_dig_en", 32'(dig_en),   32'hF);
    chk("rst_busy",   32'(busy),     32'd0);
    chk("rst_ovf",    32'(overflow), 32'd0);
    repeat (2) tick();
    chk("rst_hold_seg", 32'(seg), 32'h7F);
    rst_n = 1'b1;
    cur = model(0, 1'b0, 1'b0);

    // scan order and first switch SD cycles after release
    for (int k = 1; k <= 4 * SD + 1; k++) begin
      tick();
      chk("scan_dig_en", 32'(dig_en), 32'(~(ND'(1) << ((k / SD) % ND)) & 4'hF));
      chk_seg_now("scan_seg", cur);
    end

    do_load("hex_1a3f", 32'h1A3F, 1'b0, 1, 0);
    do_load("dec_1234", 32'h04D2, 1'b1, DW + 1, 0);
    lz_blank = 1'b1;
    do_load("hex_zero_lz", 0, 1'b0, 1, 0);
    do_load("dec_ovf", 12345, 1'b1, DW + 1, 0);
    do_load("dec_7_lz", 7, 1'b1, DW + 1, 0);
    lz_blank = 1'b0;
    do_load("dec_9999_ign", 9999, 1'b1, DW + 1, 3);
    do_load("hex_ffff", 32'hFFFF, 1'b0, 1, 0);

    // reset in the middle of a decimal conversion
    value = 16'd4321; dec_mode = 1'b1; load = 1'b1;
    sb.push_back(model(4321, 1'b1, lz_blank));
    tick();
    load = 1'b0;
    repeat (7) tick();
    chk("mid_busy", 32'(busy), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_seg",    32'(seg),      32'h7F);
    chk("mid_rst_dig_en", 32'(dig_en),   32'hF);
    chk("mid_rst_busy",   32'(busy),     32'd0);
    chk("mid_rst_ovf",    32'(overflow), 32'd0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    cur = model(0, 1'b0, lz_blank);
    tick();
    check_display("post_rst", cur);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
